// File: rtl/reg_share_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM states, sizing
// constants and the round-robin winner search.
package reg_share_pkg;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACKS  = 2'd2
  } state_t;

  // First set request bit found scanning upward from ptr, wrapping at NREQ.
  function automatic logic [1:0] rr_winner(input logic [NREQ-1:0] req,
                                           input logic [1:0]      ptr);
    logic [1:0] idx;
    logic       found;
    rr_winner = ptr;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_winner = idx;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/load_reg8.sv
// Shared data register: asynchronous active-low clear, synchronous load enable.
module load_reg8 #(
  parameter int W = reg_share_pkg::DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// register; each write takes GRANT then ACKS, with an abort path back to IDLE.
module reg_share_arbiter #(
  parameter int DW   = reg_share_pkg::DW,
  parameter int NREQ = reg_share_pkg::NREQ
) (
  input  logic                 CLK,
  input  logic                 CLRn,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*DW-1:0]   DIN,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      ACK,
  output logic [DW-1:0]        OUT,
  output logic [1:0]           OWNER,
  output logic                 BUSY,
  output logic [7:0]           WR_CNT
);
  import reg_share_pkg::*;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t          state, next_state;
  logic [1:0]      win_q, win_d;
  logic [1:0]      ptr;
  logic [NREQ-1:0] gnt_d, ack_d;
  logic            load;

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    win_d      = win_q;
    case (state)
      IDLE: begin
        if (|REQ) begin
          next_state = GRANT;
          win_d      = rr_winner(REQ, ptr);
        end
      end
      GRANT:   next_state = REQ[win_q] ? ACKS : IDLE;
      ACKS:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; only REQ[win_q] matters in GRANT.
  always_comb begin
    gnt_d = '0;
    ack_d = '0;
    load  = 1'b0;
    case (state)
      IDLE:  if (|REQ) gnt_d = ONE << win_d;
      GRANT: begin
        if (REQ[win_q]) begin
          load  = 1'b1;
          ack_d = ONE << win_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      GNT    <= '0;
      ACK    <= '0;
      BUSY   <= 1'b0;
      win_q  <= '0;
      ptr    <= '0;
      OWNER  <= '0;
      WR_CNT <= '0;
    end else begin
      GNT   <= gnt_d;
      ACK   <= ack_d;
      BUSY  <= (next_state != IDLE);
      win_q <= win_d;
      if (load) begin
        ptr    <= win_q + 2'd1;
        OWNER  <= win_q;
        WR_CNT <= WR_CNT + 8'd1;
      end
    end
  end

  load_reg8 #(.W(DW)) u_shared (
    .clk   (CLK),
    .rst_n (CLRn),
    .load  (load),
    .d     (DIN[win_q*DW +: DW]),
    .q     (OUT)
  );

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!CLRn) $onehot0(GNT));
  a_ack_onehot: assert property (@(posedge CLK) disable iff (!CLRn) $onehot0(ACK));
  a_no_overlap: assert property (@(posedge CLK) disable iff (!CLRn) !((|GNT) && (|ACK)));
  a_busy_state: assert property (@(posedge CLK) disable iff (!CLRn) BUSY == (state != IDLE));

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios plus random
// transactions compared against a transaction-level round-robin model.
module tb_reg_share_arbiter;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          CLRn;
  logic [3:0]    REQ;
  logic [4*DW-1:0] DIN;
  logic [3:0]    GNT, ACK;
  logic [DW-1:0] OUT;
  logic [1:0]    OWNER;
  logic          BUSY;
  logic [7:0]    WR_CNT;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: architectural values only.
  int         m_ptr;
  logic [7:0] m_out;
  logic [1:0] m_owner;
  logic [7:0] m_cnt;

  typedef logic [26:0] obs_t;  // {GNT, ACK, BUSY, OUT, OWNER, WR_CNT}

  always #5 CLK = ~CLK;

  reg_share_arbiter #(.DW(DW), .NREQ(4)) dut (
    .CLK    (CLK),
    .CLRn   (CLRn),
    .REQ    (REQ),
    .DIN    (DIN),
    .GNT    (GNT),
    .ACK    (ACK),
    .OUT    (OUT),
    .OWNER  (OWNER),
    .BUSY   (BUSY),
    .WR_CNT (WR_CNT)
  );

  function automatic obs_t observed();
    return {GNT, ACK, BUSY, OUT, OWNER, WR_CNT};
  endfunction

  function automatic obs_t expect_of(input logic [3:0] g, input logic [3:0] a, input logic b);
    return {g, a, b, m_out, m_owner, m_cnt};
  endfunction

  // Round-robin pick from the model pointer; -1 when nobody requests.
  function automatic int pick(input logic [3:0] req);
    for (int i = 0; i < 4; i++)
      if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_out = '0; m_owner = '0; m_cnt = '0;
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge CLK) begin
    if (CLRn === 1'b1) begin
      n_cmp++;
      if (!$onehot0(GNT) || !$onehot0(ACK) || ((GNT != 4'b0) && (ACK != 4'b0))) begin
        n_err++;
        $display("FAIL invariant: gnt=%b ack=%b must be onehot0 and disjoint", GNT, ACK);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One write attempt starting from IDLE at a falling edge.
  task automatic do_txn(input logic [3:0] req, input logic [31:0] din,
                        input bit abort, input string tag);
    int w;
    logic [3:0] bit_w, rnd;
    obs_t e;
    REQ = req; DIN = din;
    w = pick(req);
    @(negedge CLK);
    if (w < 0) begin
      e = expect_of(4'b0, 4'b0, 1'b0);
      n_cmp++;
      if (observed() !== e) begin
        n_err++; $display("FAIL %s idle: got %h exp %h", tag, observed(), e);
      end
      return;
    end
    bit_w = 4'(1 << w);
    e = expect_of(bit_w, 4'b0, 1'b1);
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL %s grant: got %h exp %h", tag, observed(), e);
    end
    rnd = 4'($urandom);
    REQ = abort ? (rnd & ~bit_w) : (rnd | bit_w);
    @(negedge CLK);
    if (abort) begin
      e = expect_of(4'b0, 4'b0, 1'b0);
      n_cmp++;
      if (observed() !== e) begin
        n_err++; $display("FAIL %s abort: got %h exp %h", tag, observed(), e);
      end
      REQ = 4'b0;
      return;
    end
    m_out = din[w*8 +: 8]; m_owner = 2'(w); m_ptr = (w + 1) % 4; m_cnt = m_cnt + 8'd1;
    e = expect_of(4'b0, bit_w, 1'b1);
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL %s write_ack: got %h exp %h", tag, observed(), e);
    end
    REQ = 4'($urandom); DIN = $urandom;
    @(negedge CLK);
    e = expect_of(4'b0, 4'b0, 1'b0);
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL %s ack_end: got %h exp %h", tag, observed(), e);
    end
    REQ = 4'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    CLRn = 1'b0;
    REQ  = 4'b0;
    @(negedge CLK);
    CLRn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    CLRn = 1'b1; REQ = 4'b0; DIN = '0;
    #1 CLRn = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== 27'b0) begin
      n_err++; $display("FAIL reset_async: got %h exp 0", observed());
    end
    @(negedge CLK);
    CLRn = 1'b1;
    model_reset();
    @(negedge CLK);
    n_cmp++;
    if (observed() !== expect_of(4'b0, 4'b0, 1'b0)) begin
      n_err++; $display("FAIL reset_release: got %h exp 0", observed());
    end
  endtask

  task automatic test_single();
    do_txn(4'b0001, 32'h0000_00A5, 1'b0, "single");
    n_cmp++;
    if ({OUT, OWNER, WR_CNT} !== {8'hA5, 2'd0, 8'd1}) begin
      n_err++; $display("FAIL single_result: got out=%h owner=%0d cnt=%0d exp a5/0/1", OUT, OWNER, WR_CNT);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 32'h1312_1110, 1'b0, "round_robin");
      want = 8'h10 + 8'(k % 4);
      n_cmp++;
      if ({OUT, OWNER} !== {want, 2'(k % 4)}) begin
        n_err++; $display("FAIL rr_order[%0d]: got out=%h owner=%0d exp %h/%0d", k, OUT, OWNER, want, k % 4);
      end
    end
  endtask

  task automatic test_abort();
    do_txn(4'b0100, $urandom, 1'b1, "abort");
    do_txn(4'b0100, $urandom, 1'b0, "after_abort");
    n_cmp++;
    if (OWNER !== 2'd2) begin
      n_err++; $display("FAIL after_abort_owner: got %0d exp 2", OWNER);
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    do_txn(4'b0010, $urandom, 1'b0, "pre_reset");
    REQ = 4'b1000; DIN = $urandom;
    @(negedge CLK);
    e = expect_of(4'b1000, 4'b0, 1'b1);
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL mid_reset_grant: got %h exp %h", observed(), e);
    end
    #2 CLRn = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== 27'b0) begin
      n_err++; $display("FAIL mid_reset_async: got %h exp 0", observed());
    end
    REQ = 4'b0;
    @(negedge CLK);
    @(negedge CLK);
    CLRn = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (observed() !== 27'b0) begin
        n_err++; $display("FAIL mid_reset_quiet[%0d]: got %h exp 0", k, observed());
      end
    end
    do_txn(4'b1111, $urandom, 1'b0, "post_reset_first");
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++)
      do_txn(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0), "random");
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 256; k++)
      do_txn(4'($urandom_range(1, 15)), $urandom, 1'b0, "wrap");
    n_cmp++;
    if ({WR_CNT, OUT} !== {8'd0, m_out}) begin
      n_err++; $display("FAIL wrap_count: got cnt=%0d out=%h exp 0/%h", WR_CNT, OUT, m_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, meaning width of the shared data register and of each requester data port.
REQ-002 SHALL have parameter NREQ, default 4, meaning the number of requesters; NREQ is fixed at 4 in this release.
REQ-003 SHALL have port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port CLRn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port REQ, input, 4, per-requester write request, level-sensitive.
REQ-006 SHALL have port DIN, input, 4*DW, requester data; requester i occupies bits [i*DW +: DW].
REQ-007 SHALL have port GNT, output, 4, one-hot grant, or all-zero when no grant.
REQ-008 SHALL have port ACK, output, 4, one-cycle pulse to the requester whose data was written.
REQ-009 SHALL have port OUT, output, DW, contents of the shared register.
REQ-010 SHALL have port OWNER, output, 2, index of the last successful writer.
REQ-011 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port WR_CNT, output, 8, count of successful writes; wraps 255->0.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, GRANT, ACKS.
REQ-014 IDLE: if any REQ bit is high, the FSM SHALL select winner W and set GNT = onehot(W), moving to GRANT on the next edge; otherwise it SHALL remain in IDLE with GNT = 0.
REQ-015 Winner selection SHALL be round-robin: search starts at pointer PTR and increments modulo 4; the first set REQ bit wins.
REQ-016 GRANT with REQ[W] still high: on the edge leaving GRANT, the block SHALL load OUT <= DIN[W], set OWNER <= W, set PTR <= (W+1) mod 4, and increment WR_CNT; the FSM then goes to ACKS.
REQ-017 GRANT with REQ[W] dropped (abort): the block SHALL not load OUT, SHALL leave PTR, OWNER and WR_CNT unchanged, and SHALL return to IDLE with no ACK pulse.
REQ-018 ACKS: ACK = onehot(W) and GNT = 0 for exactly one cycle; the FSM then returns to IDLE unconditionally.
REQ-019 Latency: from REQ sampled high in IDLE, GNT SHALL rise after 1 edge, OUT SHALL update after 2 edges, and ACK SHALL pulse in cycle 3; a minimum of 3 cycles per write.
REQ-020 REQ changes on bits other than W during GRANT or ACKS SHALL be ignored until the FSM returns to IDLE.
REQ-021 Simultaneous requests SHALL be resolved only by PTR; no requester SHALL wait more than 3 other writes.
REQ-022 GNT and ACK SHALL never both be non-zero in the same cycle, and each SHALL be at most one-hot.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 CLRn low SHALL immediately, without waiting for a clock, force: FSM=IDLE, GNT=0, ACK=0, OUT=0, OWNER=0, PTR=0, WR_CNT=0, BUSY=0.
REQ-025 Reset asserted mid-transaction SHALL discard the transaction with no ACK; the first post-reset grant SHALL follow the PTR=0 ordering.
REQ-026 Release of CLRn SHALL take effect at the first rising CLK edge after deassertion.

Structure
REQ-027 A shared package reg_share_pkg SHALL hold the FSM state enumeration, the NREQ and DW constants, and the round-robin next-winner function.
REQ-028 The shared register SHALL be one sub-module, load_reg8: a DW-bit register with asynchronous active-low clear and a synchronous load enable, instantiated once.
REQ-029 The arbiter FSM, PTR and WR_CNT SHALL reside in reg_share_arbiter itself.

Verification
REQ-030 Reset: CLRn=0 asserted mid-cycle while in GRANT -> all outputs 0 immediately, with no ACK afterward.
REQ-031 Single request: REQ=0001, DIN0=8'hA5 -> GNT=0001 at edge 1, OUT=8'hA5 with OWNER=0 and WR_CNT=1 at edge 2, ACK=0001 for one cycle.
REQ-032 Round-robin: REQ=1111 held with DINi=8'h10+i -> write order 0,1,2,3,0, OUT sequence 10,11,12,13,10, each write 3 cycles apart.
REQ-033 Abort: REQ=0100 then REQ[2] dropped during GRANT -> OUT unchanged, WR_CNT unchanged, ACK=0, FSM back in IDLE; a subsequent REQ=0100 is still granted to requester 2 at the PTR position.
REQ-034 Wrap: 256 successful writes -> WR_CNT returns to 0 after the 256th write; OUT holds the last data written.
REQ-035 Assertions SHALL run throughout all scenarios: GNT and ACK each one-hot-or-zero and never overlapping; BUSY equals (FSM != IDLE).
